// File: rtl/alarm_ring_ctrl_if.sv
// alarm_ring_ctrl_if: time/alarm inputs, buttons and ring outputs of the alarm ring controller
interface alarm_ring_ctrl_if;
  logic       tick_1hz;
  logic       alarm_on;
  logic       setting_active;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [5:0] alarm_sec;
  logic [4:0] time_hour;
  logic [5:0] time_min;
  logic [5:0] time_sec;
  logic       stop_btn;
  logic       snooze_btn;
  logic       ringing;
  logic       snoozing;
  logic       buzzer;
  logic [9:0] snooze_left;
  modport master (
    output tick_1hz, alarm_on, setting_active, alarm_hour, alarm_min, alarm_sec,
           time_hour, time_min, time_sec, stop_btn, snooze_btn,
    input  ringing, snoozing, buzzer, snooze_left
  );
  modport slave (
    input  tick_1hz, alarm_on, setting_active, alarm_hour, alarm_min, alarm_sec,
           time_hour, time_min, time_sec, stop_btn, snooze_btn,
    output ringing, snoozing, buzzer, snooze_left
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm match detection, ring/snooze sequencing and buzzer drive
module alarm_ring_ctrl #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input logic               clock,
  input logic               reset_sec,
  alarm_ring_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
  localparam logic [5:0] RING_LAST   = 6'(RING_SECONDS - 1);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MINUTES * 60);
  state_t     state, state_n;
  logic [5:0] ring_cnt, ring_cnt_n;
  logic [9:0] snooze_cnt, snooze_cnt_n;
  logic       beep_phase, beep_phase_n;
  logic       match_q, eq, match_rise, quit;
  assign eq = bus.alarm_on & ~bus.setting_active & (bus.alarm_hour == bus.time_hour) &
              (bus.alarm_min == bus.time_min) & (bus.alarm_sec == bus.time_sec);
  assign match_rise = eq & ~match_q;
  assign quit = ~bus.alarm_on | bus.stop_btn;
  // state and counters; match_q remembers eq so a held equality rings only once
  always_ff @(posedge clock or posedge reset_sec)
    if (reset_sec) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      beep_phase <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      state      <= state_n;
      ring_cnt   <= ring_cnt_n;
      snooze_cnt <= snooze_cnt_n;
      beep_phase <= beep_phase_n;
      match_q    <= eq;
    end
  // next state: disarm/stop beat snooze, which beats the tick-driven moves
  always_comb begin
    state_n      = state;
    ring_cnt_n   = ring_cnt;
    snooze_cnt_n = snooze_cnt;
    beep_phase_n = beep_phase;
    case (state)
      IDLE:
        if (match_rise) begin
          state_n      = RINGING;
          ring_cnt_n   = '0;
          beep_phase_n = 1'b1;
        end
      RINGING:
        if (quit) state_n = IDLE;
        else if (bus.snooze_btn) begin
          state_n      = SNOOZE;
          snooze_cnt_n = SNOOZE_LOAD;
        end else if (bus.tick_1hz) begin
          beep_phase_n = ~beep_phase;
          if (ring_cnt == RING_LAST) state_n = IDLE;
          else ring_cnt_n = ring_cnt + 6'd1;
        end
      SNOOZE:
        if (quit) begin
          state_n      = IDLE;
          snooze_cnt_n = '0;
        end else if (bus.tick_1hz) begin
          if (snooze_cnt == 10'd1) begin
            state_n      = RINGING;
            ring_cnt_n   = '0;
            beep_phase_n = 1'b1;
            snooze_cnt_n = '0;
          end else snooze_cnt_n = snooze_cnt - 10'd1;
        end
      default: state_n = IDLE;
    endcase
  end
  // outputs decode registered state only, so inputs never reach them combinationally
  always_comb begin
    bus.ringing     = state == RINGING;
    bus.snoozing    = state == SNOOZE;
    bus.buzzer      = (state == RINGING) & beep_phase;
    bus.snooze_left = snooze_cnt;
  end
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed scenarios with a queued scoreboard checked by a separate monitor
module tb_alarm_ring_ctrl;
  logic clock = 1'b0;
  logic reset_sec = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  event sample_ev;
  typedef struct {
    string      nm;
    logic [12:0] v;
  } exp_t;
  exp_t sb[$];
  alarm_ring_ctrl_if bus ();
  alarm_ring_ctrl #(.RING_SECONDS(60), .SNOOZE_MINUTES(5)) dut (
    .clock(clock),
    .reset_sec(reset_sec),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  initial forever begin
    @(negedge clock or sample_ev);
    while (sb.size() > 0) begin
      automatic exp_t e = sb.pop_front();
      automatic logic [12:0] act = {bus.ringing, bus.snoozing, bus.buzzer, bus.snooze_left};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got ring=%b snz=%b buz=%b left=%0d, want ring=%b snz=%b buz=%b left=%0d",
                 e.nm, act[12], act[11], act[10], act[9:0], e.v[12], e.v[11], e.v[10], e.v[9:0]);
      end
    end
  end
  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: run did not complete within the time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end
  task automatic cyc(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic tick();
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
  endtask
  task automatic press_stop();
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
  endtask
  task automatic press_snooze();
    bus.snooze_btn = 1'b1;
    cyc();
    bus.snooze_btn = 1'b0;
  endtask
  task automatic expect_o(string nm, logic r, logic s, logic b, logic [9:0] sl);
    sb.push_back('{nm, {r, s, b, sl}});
  endtask
  task automatic start_ring();
    bus.time_sec = 6'd16;
    cyc();
    bus.time_sec = 6'd15;
    cyc();
  endtask
  initial begin
    bus.tick_1hz = 0; bus.alarm_on = 0; bus.setting_active = 0;
    bus.alarm_hour = 0; bus.alarm_min = 0; bus.alarm_sec = 0;
    bus.time_hour = 0; bus.time_min = 0; bus.time_sec = 0;
    bus.stop_btn = 0; bus.snooze_btn = 0;
    cyc(2);
    expect_o("reset", 0, 0, 0, 0);
    reset_sec = 1'b0;
    bus.alarm_hour = 5'd7; bus.alarm_min = 6'd30; bus.alarm_sec = 6'd15;
    bus.time_hour = 5'd7; bus.time_min = 6'd30; bus.time_sec = 6'd14;
    bus.alarm_on = 1'b1;
    cyc();
    expect_o("pre_match", 0, 0, 0, 0);
    bus.time_sec = 6'd15;
    expect_o("no_comb_path", 0, 0, 0, 0);
    cyc();
    expect_o("match", 1, 0, 1, 0);
    cyc(3);
    expect_o("hold_match", 1, 0, 1, 0);
    tick();
    expect_o("tick1", 1, 0, 0, 0);
    cyc(2);
    expect_o("no_retrigger", 1, 0, 0, 0);
    bus.time_sec = 6'd16;
    for (int k = 2; k <= 59; k++) begin
      tick();
      expect_o($sformatf("ring_tick%0d", k), 1, 0, (k % 2) == 0, 0);
    end
    tick();
    expect_o("auto_timeout", 0, 0, 0, 0);
    start_ring();
    expect_o("ring_again", 1, 0, 1, 0);
    press_snooze();
    expect_o("snooze_load", 0, 1, 0, 10'd300);
    for (int k = 1; k <= 299; k++) begin
      tick();
      expect_o($sformatf("snooze_tick%0d", k), 0, 1, 0, 10'(300 - k));
      if (k == 100) begin
        press_snooze();
        expect_o("snooze_ignored", 0, 1, 0, 10'd200);
      end
    end
    tick();
    expect_o("snooze_wake", 1, 0, 1, 0);
    bus.stop_btn = 1'b1;
    bus.snooze_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
    bus.snooze_btn = 1'b0;
    expect_o("stop_and_snooze", 0, 0, 0, 0);
    start_ring();
    press_snooze();
    repeat (3) tick();
    expect_o("snooze_297", 0, 1, 0, 10'd297);
    press_stop();
    expect_o("stop_in_snooze", 0, 0, 0, 0);
    start_ring();
    repeat (59) tick();
    expect_o("ring_59", 1, 0, 0, 0);
    bus.tick_1hz = 1'b1;
    bus.snooze_btn = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
    bus.snooze_btn = 1'b0;
    expect_o("snooze_beats_timeout", 0, 1, 0, 10'd300);
    press_stop();
    expect_o("stop_after_late_snooze", 0, 0, 0, 0);
    start_ring();
    bus.alarm_on = 1'b0;
    cyc();
    expect_o("alarm_off_mid_ring", 0, 0, 0, 0);
    start_ring();
    cyc(2);
    expect_o("disarmed_no_ring", 0, 0, 0, 0);
    bus.time_sec = 6'd16;
    bus.setting_active = 1'b1;
    bus.alarm_on = 1'b1;
    cyc();
    bus.time_sec = 6'd15;
    cyc(3);
    expect_o("setting_no_ring", 0, 0, 0, 0);
    bus.time_sec = 6'd16;
    cyc();
    bus.setting_active = 1'b0;
    bus.time_sec = 6'd15;
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
    expect_o("match_over_stop", 1, 0, 1, 0);
    press_snooze();
    repeat (180) tick();
    expect_o("snooze_120", 0, 1, 0, 10'd120);
    @(negedge clock);
    #2;
    reset_sec = 1'b1;
    #1;
    if ({bus.ringing, bus.snoozing, bus.buzzer, bus.snooze_left} !== 13'd0) begin
      miscompares++;
      $display("FAIL async_reset_direct: outputs not cleared immediately");
    end
    expect_o("async_reset", 0, 0, 0, 0);
    -> sample_ev;
    cyc(2);
    expect_o("reset_held", 0, 0, 0, 0);
    reset_sec = 1'b0;
    expect_o("reset_release", 0, 0, 0, 0);
    cyc();
    expect_o("fresh_rise_after_reset", 1, 0, 1, 0);
    @(negedge clock);
    #1;
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL coverage: only %0d vectors compared", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $fatal(1);
    $display("PASS");
    $finish;
  end
endmodule
